// File: rtl/pb_pkg.sv
// Shared definitions for the pushbutton conditioner.
//   PB_N             default number of buttons (at most 32)
//   PB_TICK_DIV      default clock cycles per debounce sample tick
//   PB_STABLE_TICKS  default number of consecutive differing samples that accept a new level
//   PB_REPEAT_*      default auto-repeat timing in ticks (used when PB_AUTOREPEAT_EN is defined)
//   key_code_t       5-bit button index
//   lowest_set()     index of the lowest set bit of a 32-bit vector (0 when none is set)
package pb_pkg;

    localparam int PB_N            = 21;
    localparam int PB_TICK_DIV     = 12000;
    localparam int PB_STABLE_TICKS = 4;
    localparam int PB_REPEAT_DELAY = 500;
    localparam int PB_REPEAT_RATE  = 100;

    typedef logic [4:0] key_code_t;

    function automatic key_code_t lowest_set(input logic [31:0] v);
        key_code_t idx;
        idx = '0;
        // Scan downwards so that the last hit, i.e. the lowest index, is kept.
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                idx = key_code_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pb_debounce_cell.sv
// Debounce and rising-edge detect for a single, already synchronised button.
//   hwclk   system clock
//   reset   asynchronous active-low reset
//   tick    one-cycle sample strobe shared by all cells
//   d_sync  synchronised raw button level
//   level   debounced level
//   rise    one-cycle pulse the cycle after level goes 0->1
module pb_debounce_cell
    import pb_pkg::*;
#(
    parameter int STABLE_TICKS = PB_STABLE_TICKS
) (
    input  logic hwclk,
    input  logic reset,
    input  logic tick,
    input  logic d_sync,
    output logic level,
    output logic rise
);

    // The counter only has to hold values up to STABLE_TICKS-1.
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

    logic [CW-1:0] cnt_reg;
    logic          level_reg;
    logic          prev_reg;
    logic          rise_reg;

    always_ff @(posedge hwclk or negedge reset) begin
        if (!reset) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            prev_reg  <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            if (tick) begin
                if (d_sync == level_reg) begin
                    // Input agrees with the accepted level: any bounce in progress is forgotten.
                    cnt_reg <= '0;
                end else if (cnt_reg == CW'(STABLE_TICKS - 1)) begin
                    // This is the STABLE_TICKS-th differing sample in a row.
                    level_reg <= d_sync;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end
            prev_reg <= level_reg;
            rise_reg <= level_reg & ~prev_reg;
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/pb_conditioner.sv
// Pushbutton front end: synchronise, debounce, edge-detect and encode the newest press.
//   hwclk       system clock
//   reset       asynchronous active-low reset
//   pb          raw asynchronous buttons, 1 = pressed
//   pb_level    debounced button state
//   pb_rise     one-cycle pulse per button on each debounced 0->1 transition
//   key_strobe  one-cycle pulse: key_code is valid
//   key_code    index of the button that caused key_strobe
//   key_held    1 while the button named by key_code is debounced-high
// Build option: define PB_AUTOREPEAT_EN to add auto-repeat strobes while a key is held.
module pb_conditioner
    import pb_pkg::*;
#(
    parameter int N            = PB_N,
    parameter int TICK_DIV     = PB_TICK_DIV,
    parameter int STABLE_TICKS = PB_STABLE_TICKS,
    parameter int REPEAT_DELAY = PB_REPEAT_DELAY,
    parameter int REPEAT_RATE  = PB_REPEAT_RATE
) (
    input  logic         hwclk,
    input  logic         reset,
    input  logic [N-1:0] pb,
    output logic [N-1:0] pb_level,
    output logic [N-1:0] pb_rise,
    output logic         key_strobe,
    output key_code_t    key_code,
    output logic         key_held
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [N-1:0]  sync1_reg;
    logic [N-1:0]  sync2_reg;
    logic [PW-1:0] presc_reg;
    logic          tick;
    logic [31:0]   rise_vec;
    logic [31:0]   level_vec;
    logic          key_strobe_reg;
    key_code_t     key_code_reg;

    // Two-flop synchroniser; nothing else looks at pb.
    always_ff @(posedge hwclk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= pb;
            sync2_reg <= sync1_reg;
        end
    end

    // Sample-tick prescaler.
    assign tick = (presc_reg == PW'(TICK_DIV - 1));

    always_ff @(posedge hwclk or negedge reset) begin
        if (!reset) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cell
            pb_debounce_cell #(
                .STABLE_TICKS(STABLE_TICKS)
            ) u_cell (
                .hwclk (hwclk),
                .reset (reset),
                .tick  (tick),
                .d_sync(sync2_reg[gi]),
                .level (pb_level[gi]),
                .rise  (pb_rise[gi])
            );
        end
    endgenerate

    // Widen to 32 bits so the encoder and the held lookup never index past the vector.
    assign rise_vec  = 32'(pb_rise);
    assign level_vec = 32'(pb_level);
    assign key_held  = level_vec[key_code_reg];

`ifdef PB_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt_reg;
    logic          rpt_phase_reg;   // 0: waiting for the first repeat, 1: repeating at REPEAT_RATE
    logic [RW-1:0] rpt_inc;
    logic [RW-1:0] rpt_target;

    assign rpt_inc    = rpt_reg + RW'(1);
    assign rpt_target = rpt_phase_reg ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);

    always_ff @(posedge hwclk or negedge reset) begin
        if (!reset) begin
            key_strobe_reg <= 1'b0;
            key_code_reg   <= '0;
            rpt_reg        <= '0;
            rpt_phase_reg  <= 1'b0;
        end else begin
            key_strobe_reg <= 1'b0;
            if (|pb_rise) begin
                // A fresh press always wins over a repeat due in the same cycle.
                key_strobe_reg <= 1'b1;
                key_code_reg   <= lowest_set(rise_vec);
                rpt_reg        <= '0;
                rpt_phase_reg  <= 1'b0;
            end else if (!key_held) begin
                rpt_reg       <= '0;
                rpt_phase_reg <= 1'b0;
            end else if (tick) begin
                if (rpt_inc == rpt_target) begin
                    key_strobe_reg <= 1'b1;
                    rpt_reg        <= '0;
                    rpt_phase_reg  <= 1'b1;
                end else begin
                    rpt_reg <= rpt_inc;
                end
            end
        end
    end
`else
    // Repeat timing has no effect in this build.
    logic unused_cfg;
    assign unused_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);

    always_ff @(posedge hwclk or negedge reset) begin
        if (!reset) begin
            key_strobe_reg <= 1'b0;
            key_code_reg   <= '0;
        end else begin
            key_strobe_reg <= |pb_rise;
            if (|pb_rise) begin
                key_code_reg <= lowest_set(rise_vec);
            end
        end
    end
`endif

    assign key_strobe = key_strobe_reg;
    assign key_code   = key_code_reg;

endmodule

// File: tb/tb_pb_conditioner.sv
// Randomised scoreboard bench for pb_conditioner. A behavioural model predicts the debounced
// levels and queues every expected rise pulse and key strobe with the cycle it should appear;
// a monitor on the falling edge pops and compares whenever the design presents one.
module tb_pb_conditioner;
    import pb_pkg::*;

    localparam int N  = 21;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic         hwclk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] pb    = '0;
    logic [N-1:0] pb_level;
    logic [N-1:0] pb_rise;
    logic         key_strobe;
    key_code_t    key_code;
    logic         key_held;

    pb_conditioner #(
        .N(N), .TICK_DIV(TD), .STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .hwclk     (hwclk),
        .reset     (reset),
        .pb        (pb),
        .pb_level  (pb_level),
        .pb_rise   (pb_rise),
        .key_strobe(key_strobe),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    always #5 hwclk = ~hwclk;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;

    always @(posedge hwclk) cyc <= cyc + 1;

    typedef struct { int unsigned at; logic [N-1:0] vec; } rise_ev_t;
    typedef struct { int unsigned at; int code; } key_ev_t;

    rise_ev_t rise_q[$];
    key_ev_t  key_q[$];

    // Model state
    logic [N-1:0] m_pin_d1, m_pin_d2;   // pins delayed by one and two clocks
    logic [N-1:0] m_level, m_prev, m_rise;
    int           m_run[N];            // consecutive samples disagreeing with m_level
    int           m_cycle_in_tick;
    int           m_key;
    int           m_held_ticks, m_nrep;
    logic         m_is_tick, m_held_pre;
    logic [N-1:0] m_sample, m_rise_new;
    int           m_code;

    always @(posedge hwclk or negedge reset) begin
        if (!reset) begin
            m_pin_d1 = '0; m_pin_d2 = '0;
            m_level = '0; m_prev = '0; m_rise = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
            m_cycle_in_tick = 0;
            m_key = 0; m_held_ticks = 0; m_nrep = 0;
            rise_q.delete();
            key_q.delete();
        end else begin
            m_is_tick = (m_cycle_in_tick == TD - 1);
            m_cycle_in_tick = (m_cycle_in_tick + 1) % TD;
            m_sample   = m_pin_d2;
            m_held_pre = m_level[m_key];

            // Key events: a rise seen in the previous cycle produces a strobe now.
            if (m_rise != '0) begin
                m_code = 0;
                for (int i = N - 1; i >= 0; i--) if (m_rise[i]) m_code = i;
                key_q.push_back('{at: cyc + 1, code: m_code});
                m_key = m_code;
                m_held_ticks = 0;
                m_nrep = 0;
            end
`ifdef PB_AUTOREPEAT_EN
            else if (!m_held_pre) begin
                m_held_ticks = 0;
                m_nrep = 0;
            end else if (m_is_tick) begin
                m_held_ticks++;
                if (m_held_ticks == RD + m_nrep * RR) begin
                    key_q.push_back('{at: cyc + 1, code: m_key});
                    m_nrep++;
                end
            end
`endif

            m_rise_new = m_level & ~m_prev;
            m_prev = m_level;

            if (m_is_tick) begin
                for (int i = 0; i < N; i++) begin
                    if (m_sample[i] != m_level[i]) begin
                        m_run[i]++;
                        if (m_run[i] == ST) begin
                            m_level[i] = m_sample[i];
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end

            m_rise = m_rise_new;
            if (m_rise_new != '0) rise_q.push_back('{at: cyc + 1, vec: m_rise_new});

            m_pin_d2 = m_pin_d1;
            m_pin_d1 = pb;
        end
    end

    // Monitor
    rise_ev_t r_ev;
    key_ev_t  k_ev;

    always @(negedge hwclk) begin
        if (reset) begin
            if (pb_rise != '0) begin
                checks++;
                if (rise_q.size() == 0) begin
                    failures++;
                    $display("FAIL rise_unexpected cyc=%0d got=%h want=none", cyc, pb_rise);
                end else begin
                    r_ev = rise_q.pop_front();
                    if (r_ev.at != cyc || r_ev.vec != pb_rise) begin
                        failures++;
                        $display("FAIL rise cyc=%0d got=%h want=%h@%0d", cyc, pb_rise, r_ev.vec, r_ev.at);
                    end
                end
            end else if (rise_q.size() > 0 && rise_q[0].at <= cyc) begin
                checks++;
                failures++;
                r_ev = rise_q.pop_front();
                $display("FAIL rise_missing cyc=%0d got=0 want=%h@%0d", cyc, r_ev.vec, r_ev.at);
            end

            if (key_strobe) begin
                checks++;
                if (key_q.size() == 0) begin
                    failures++;
                    $display("FAIL strobe_unexpected cyc=%0d got code=%0d want=none", cyc, key_code);
                end else begin
                    k_ev = key_q.pop_front();
                    if (k_ev.at != cyc || int'(key_code) != k_ev.code) begin
                        failures++;
                        $display("FAIL strobe cyc=%0d got code=%0d want code=%0d@%0d", cyc, key_code, k_ev.code, k_ev.at);
                    end
                end
            end else if (key_q.size() > 0 && key_q[0].at <= cyc) begin
                checks++;
                failures++;
                k_ev = key_q.pop_front();
                $display("FAIL strobe_missing cyc=%0d got=none want code=%0d@%0d", cyc, k_ev.code, k_ev.at);
            end

            checks++;
            if (pb_level !== m_level) begin
                failures++;
                $display("FAIL level cyc=%0d got=%h want=%h", cyc, pb_level, m_level);
            end
            checks++;
            if (int'(key_code) != m_key || key_held !== m_level[m_key]) begin
                failures++;
                $display("FAIL key_state cyc=%0d got code=%0d held=%b want code=%0d held=%b",
                         cyc, key_code, key_held, m_key, m_level[m_key]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge hwclk);
        #1;
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    int op, idx, idx2, len;

    initial begin
        // Power-on reset
        reset = 1'b0;
        pb = '0;
        step(3);
        reset = 1'b1;
        step(10);

        // Clean press on button 5
        pb[5] = 1'b1;
        step(40);
        check_val("press5_level", int'(pb_level[5]), 1);
        check_val("press5_code", int'(key_code), 5);
        check_val("press5_held", int'(key_held), 1);

        // Release of button 5
        pb[5] = 1'b0;
        step(30);
        check_val("release5_level", int'(pb_level[5]), 0);
        check_val("release5_held", int'(key_held), 0);
        check_val("release5_code", int'(key_code), 5);

        // Bouncing button 7, ends released
        for (int k = 0; k < 10; k++) begin
            pb[7] = ~pb[7];
            step(3);
        end
        step(30);
        check_val("bounce7_level", int'(pb_level[7]), 0);

        // Simultaneous press of 3 and 12
        pb[3] = 1'b1;
        pb[12] = 1'b1;
        step(40);
        check_val("simul_code", int'(key_code), 3);
        pb[3] = 1'b0;
        pb[12] = 1'b0;
        step(30);

        // Long hold of 9 with 2 pressed part way through
        pb[9] = 1'b1;
        step(70);
        pb[2] = 1'b1;
        step(40);
        check_val("preempt_code", int'(key_code), 2);
        pb[2] = 1'b0;
        pb[9] = 1'b0;
        step(30);

        // Reset in the middle of debouncing with every button held
        pb = '1;
        step(6);
        reset = 1'b0;
        #2;
        checks++;
        if ({pb_level, pb_rise, key_strobe, key_code, key_held} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got level=%h rise=%h strobe=%b code=%0d held=%b want all 0",
                     pb_level, pb_rise, key_strobe, key_code, key_held);
        end
        step(3);
        reset = 1'b1;
        step(2 + TD * ST + 1);
        check_val("reset_reaccept_level", int'(pb_level == '1), 1);
        step(10);
        check_val("reset_reaccept_code", int'(key_code), 0);
        pb = '0;
        step(30);

        // Random presses, releases and bounces
        for (int it = 0; it < 300; it++) begin
            op  = int'($urandom_range(0, 3));
            idx = int'($urandom_range(0, N - 1));
            case (op)
                0, 1: begin
                    pb[idx] = ~pb[idx];
                    step(int'($urandom_range(1, 25)));
                end
                2: begin
                    len = int'($urandom_range(2, 6));
                    for (int k = 0; k < len; k++) begin
                        pb[idx] = ~pb[idx];
                        step(int'($urandom_range(1, 3)));
                    end
                end
                default: begin
                    idx2 = int'($urandom_range(0, N - 1));
                    pb[idx]  = 1'b1;
                    pb[idx2] = 1'b1;
                    step(int'($urandom_range(10, 40)));
                end
            endcase
        end
        pb = '0;
        step(60);

        check_val("rise_queue_drained", rise_q.size(), 0);
        check_val("key_queue_drained", key_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
